retire_trace_fifo: RTL and testbench

Synthesizable retirement-trace recorder for the pipelined processor.
- Classifies each retired instruction from the writeback/memory commit signals into a typed trace record.
- Stamps each record with an instruction number and cycle number, and buffers records in a parametrised FIFO for a bench or debug port to drain.
- On halt it stops accepting commits, drains, then asserts done. It replaces the ad-hoc per-cycle logging the bench did combinationally.

---
 rtl/retire_trace_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_retire_trace_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo
//   Records every retired instruction as a typed trace record. Each record
//   carries an instruction number and a cycle stamp, and is queued in a
//   DEPTH-entry FIFO that a bench or debug port drains. A HALT commit stops
//   intake. The block then drains, and `done` asserts once nothing is left.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   commit_*           writeback/memory commit view of the retiring instruction
//   rec_valid/ready    head-of-FIFO handshake. rec_valid never depends on rec_ready
//   rec_kind..mdata    head record fields; all zero when the FIFO is empty
//   count              FIFO occupancy (0..DEPTH)
//   overflow           sticky flag: a record was dropped
//   drop_count         number of dropped records, saturating
//   done               halt recorded and everything drained
module retire_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic                     commit_halt,
  input  logic                     commit_reg_wr,
  input  logic [REG_W-1:0]         commit_wr_reg,
  input  logic [DATA_W-1:0]        commit_wr_data,
  input  logic                     commit_mem_rd,
  input  logic                     commit_mem_wr,
  input  logic [DATA_W-1:0]        commit_mem_addr,
  input  logic [DATA_W-1:0]        commit_mem_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [2:0]               rec_kind,
  output logic [CNT_W-1:0]         rec_inum,
  output logic [CNT_W-1:0]         rec_cycle,
  output logic [PC_W-1:0]          rec_pc,
  output logic [REG_W-1:0]         rec_reg,
  output logic [DATA_W-1:0]        rec_wdata,
  output logic [DATA_W-1:0]        rec_addr,
  output logic [DATA_W-1:0]        rec_mdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  typedef enum logic [2:0] {
    K_NOP   = 3'd0,
    K_REG   = 3'd1,
    K_LOAD  = 3'd2,
    K_STORE = 3'd3,
    K_STU   = 3'd4,
    K_HALT  = 3'd5
  } kind_e;

  typedef struct packed {
    kind_e             kind;
    logic [CNT_W-1:0]  inum;
    logic [CNT_W-1:0]  cycle;
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  state_e            state_q, state_d;
  rec_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  inum_q, cycle_q, drop_count_q;
  logic              overflow_q;
  logic              skid_valid_q;
  rec_t              skid_q;

  rec_t              new_rec, push_rec, head;
  logic              full, pop, accept, push, skid_load, skid_clear, drop;

  // Classify the retiring instruction. Fields that a kind does not use stay zero.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    new_rec       = '0;
    new_rec.inum  = inum_q;
    new_rec.cycle = cycle_q;
    new_rec.pc    = commit_pc;
    if (commit_halt) begin
      new_rec.kind = K_HALT;
    end else if (commit_reg_wr && commit_mem_wr) begin
      new_rec.kind  = K_STU;
      new_rec.rd    = commit_wr_reg;
      new_rec.wdata = commit_wr_data;
      new_rec.addr  = commit_mem_addr;
      new_rec.mdata = commit_mem_data;
    end else if (commit_reg_wr && commit_mem_rd) begin
      new_rec.kind  = K_LOAD;
      new_rec.rd    = commit_wr_reg;
      new_rec.wdata = commit_wr_data;
      new_rec.addr  = commit_mem_addr;
    end else if (commit_reg_wr) begin
      new_rec.kind  = K_REG;
      new_rec.rd    = commit_wr_reg;
      new_rec.wdata = commit_wr_data;
    end else if (commit_mem_wr) begin
      new_rec.kind  = K_STORE;
      new_rec.addr  = commit_mem_addr;
      new_rec.mdata = commit_mem_data;
    end
  end

  assign full   = (count_q == CW'(DEPTH));
  assign pop    = (count_q != '0) && rec_ready;
  assign accept = commit_valid && (state_q == S_RUN);

  // Push arbitration. A full FIFO still accepts a push when a pop frees the
  // slot in the same cycle. The skid can only hold the halt, so it only
  // competes for a slot in DRAIN, where commits are ignored.
  always_comb begin
    push       = 1'b0;
    push_rec   = new_rec;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    drop       = 1'b0;
    if (accept) begin
      if (!full || pop)     push      = 1'b1;
      else if (commit_halt) skid_load = 1'b1;
      else                  drop      = 1'b1;
    end else if ((state_q == S_DRAIN) && skid_valid_q && (!full || pop)) begin
      push       = 1'b1;
      push_rec   = skid_q;
      skid_clear = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept && commit_halt) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !skid_valid_q) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inum_q       <= '0;
      cycle_q      <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cycle_q  <= cycle_q + CNT_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Dropped commits still consume a number, so gaps in inum expose drops.
      if (accept) inum_q <= inum_q + CNT_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_W'(1);
      end
      if (skid_load) begin
        skid_valid_q <= 1'b1;
        skid_q       <= new_rec;
      end else if (skid_clear) begin
        skid_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset. Entries are only visible while
  // count_q covers them, and the output mux below zeroes the empty case.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign rec_valid  = (count_q != '0);
  assign rec_kind   = head.kind;
  assign rec_inum   = head.inum;
  assign rec_cycle  = head.cycle;
  assign rec_pc     = head.pc;
  assign rec_reg    = head.rd;
  assign rec_wdata  = head.wdata;
  assign rec_addr   = head.addr;
  assign rec_mdata  = head.mdata;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo with default parameters (DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_retire_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_halt, commit_reg_wr, commit_mem_rd, commit_mem_wr;
  logic [15:0] commit_pc, commit_wr_data, commit_mem_addr, commit_mem_data;
  logic [2:0]  commit_wr_reg;
  logic        rec_valid, rec_ready;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum, rec_cycle;
  logic [15:0] rec_pc, rec_wdata, rec_addr, rec_mdata;
  logic [2:0]  rec_reg;
  logic [4:0]  count;
  logic        overflow, done;
  logic [31:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] tb_cycle;

  retire_trace_fifo dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_halt(commit_halt),
    .commit_reg_wr(commit_reg_wr), .commit_wr_reg(commit_wr_reg),
    .commit_wr_data(commit_wr_data), .commit_mem_rd(commit_mem_rd),
    .commit_mem_wr(commit_mem_wr), .commit_mem_addr(commit_mem_addr),
    .commit_mem_data(commit_mem_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_cycle(rec_cycle), .rec_pc(rec_pc), .rec_reg(rec_reg),
    .rec_wdata(rec_wdata), .rec_addr(rec_addr), .rec_mdata(rec_mdata),
    .count(count), .overflow(overflow), .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  // Reference cycle count: clock edges since reset was released.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cycle <= '0;
    else     tb_cycle <= tb_cycle + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    commit_valid = 0; commit_halt = 0; commit_reg_wr = 0; commit_mem_rd = 0;
    commit_mem_wr = 0; commit_pc = '0; commit_wr_reg = '0; commit_wr_data = '0;
    commit_mem_addr = '0; commit_mem_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rec_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one commit for one clock edge, starting from a falling edge.
  task automatic do_commit(input logic [15:0] pc, input logic halt, input logic reg_wr,
                           input logic [2:0] rd, input logic [15:0] wdata,
                           input logic mem_rd, input logic mem_wr,
                           input logic [15:0] addr, input logic [15:0] mdata);
    commit_valid = 1; commit_pc = pc; commit_halt = halt; commit_reg_wr = reg_wr;
    commit_wr_reg = rd; commit_wr_data = wdata; commit_mem_rd = mem_rd;
    commit_mem_wr = mem_wr; commit_mem_addr = addr; commit_mem_data = mdata;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    logic [31:0] exp_cyc;
    int          popped;
    logic        halt_seen;
    logic [31:0] halt_inum;
    logic [15:0] halt_pc, halt_wdata;
    logic [2:0]  halt_reg;

    rst = 1'b1;
    rec_ready = 1'b0;
    idle_inputs();
    #1;
    check("rst_valid", rec_valid, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
    check("rst_kind", rec_kind, 0);
    check("rst_inum", rec_inum, 0);

    // Single register write, consumer ready.
    rec_ready = 1'b1;
    exp_cyc = tb_cycle;
    do_commit(16'h0000, 0, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0);
    check("reg_valid", rec_valid, 1);
    check("reg_kind", rec_kind, 1);
    check("reg_inum", rec_inum, 0);
    check("reg_cycle", rec_cycle, exp_cyc);
    check("reg_rd", rec_reg, 3);
    check("reg_wdata", rec_wdata, 16'h1234);
    check("reg_addr", rec_addr, 0);
    @(negedge clk);
    check("reg_popped", count, 0);

    // Load, stu, store, nop back to back; unused fields must come out zero.
    do_reset();
    do_commit(16'h0002, 0, 1, 3'd5, 16'h00AA, 1, 0, 16'h0040, 16'h5555);
    do_commit(16'h0004, 0, 1, 3'd6, 16'h0042, 0, 1, 16'h0042, 16'hBEEF);
    do_commit(16'h0006, 0, 0, 3'd7, 16'h1111, 0, 1, 16'h0080, 16'hCAFE);
    do_commit(16'h0008, 0, 0, 3'd2, 16'h2222, 1, 0, 16'h0090, 16'h3333);
    check("mix_count", count, 4);
    check("load_kind", rec_kind, 2);
    check("load_inum", rec_inum, 0);
    check("load_addr", rec_addr, 16'h0040);
    check("load_mdata", rec_mdata, 0);
    check("load_wdata", rec_wdata, 16'h00AA);
    rec_ready = 1'b1; @(negedge clk); rec_ready = 1'b0;
    check("stu_kind", rec_kind, 4);
    check("stu_inum", rec_inum, 1);
    check("stu_addr", rec_addr, 16'h0042);
    check("stu_mdata", rec_mdata, 16'hBEEF);
    check("stu_rd", rec_reg, 6);
    rec_ready = 1'b1; @(negedge clk); rec_ready = 1'b0;
    check("store_kind", rec_kind, 3);
    check("store_rd", rec_reg, 0);
    check("store_wdata", rec_wdata, 0);
    check("store_mdata", rec_mdata, 16'hCAFE);
    rec_ready = 1'b1; @(negedge clk); rec_ready = 1'b0;
    check("nop_kind", rec_kind, 0);
    check("nop_pc", rec_pc, 16'h0008);
    check("nop_addr", rec_addr, 0);
    check("nop_rd", rec_reg, 0);

    // Overflow: 18 commits into a 16-entry FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 18; i++)
      do_commit(16'(i * 2), 0, 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 2);
    rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_inum", rec_inum, i);
      @(negedge clk);
    end
    rec_ready = 1'b0;
    check("ovf_empty", count, 0);
    do_commit(16'h0100, 0, 1, 3'd1, 16'h0, 0, 0, 16'h0, 16'h0);
    check("ovf_next_inum", rec_inum, 18);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop for 5 cycles.
    do_reset();
    for (int i = 0; i < 16; i++)
      do_commit(16'(i), 0, 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0);
    check("pp_full", count, 16);
    rec_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      do_commit(16'(i + 16), 0, 1, 3'd1, 16'h0, 0, 0, 16'h0, 16'h0);
    rec_ready = 1'b0;
    check("pp_count", count, 16);
    check("pp_overflow", overflow, 0);
    check("pp_drops", drop_count, 0);
    check("pp_head_inum", rec_inum, 5);

    // Halt while full goes to the skid; later commits are ignored.
    do_commit(16'h0020, 1, 1, 3'd2, 16'h0099, 0, 0, 16'h0, 16'h0);
    check("halt_full_count", count, 16);
    check("halt_no_drop", overflow, 0);
    check("halt_not_done", done, 0);
    do_commit(16'h0030, 0, 1, 3'd1, 16'h0, 0, 0, 16'h0, 16'h0);
    do_commit(16'h0032, 0, 1, 3'd1, 16'h0, 0, 0, 16'h0, 16'h0);
    check("drain_ignored_count", count, 16);
    check("drain_ignored_drops", drop_count, 0);
    rec_ready = 1'b1;
    popped = 0; halt_seen = 0; halt_inum = '0; halt_pc = '0; halt_reg = '0; halt_wdata = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (rec_valid) begin
        popped++;
        if (rec_kind == 3'd5) begin
          halt_seen = 1; halt_inum = rec_inum; halt_pc = rec_pc;
          halt_reg = rec_reg; halt_wdata = rec_wdata;
        end
      end
      @(negedge clk);
    end
    rec_ready = 1'b0;
    check("halt_seen", halt_seen, 1);
    check("halt_inum", halt_inum, 21);
    check("halt_pc", halt_pc, 16'h0020);
    check("halt_rd_zero", halt_reg, 0);
    check("halt_wdata_zero", halt_wdata, 0);
    check("halt_popped", popped, 17);
    check("halt_done", done, 1);
    check("halt_empty", count, 0);

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_commit(16'(i), 0, 1, 3'd1, 16'h0, 0, 0, 16'h0, 16'h0);
    do_commit(16'h0040, 1, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0);
    check("mid_count", count, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", rec_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cyc = tb_cycle;
    do_commit(16'h0050, 0, 1, 3'd4, 16'h0777, 0, 0, 16'h0, 16'h0);
    check("mid_new_count", count, 1);
    check("mid_new_inum", rec_inum, 0);
    check("mid_new_cycle", rec_cycle, exp_cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
